// File: rtl/turn_arbiter_if.sv
// turn_arbiter_if: player inputs, board flag and cursor/write outputs.
// master = keyboard/board side, slave = turn_arbiter.
interface turn_arbiter_if;
  logic       start;
  logic       abort;
  logic [3:0] p0_dir;
  logic       p0_place;
  logic [3:0] p1_dir;
  logic       p1_place;
  logic       occupied;
  logic [3:0] curh;
  logic [3:0] curv;
  logic [1:0] user;
  logic       place_we;
  logic [3:0] place_h;
  logic [3:0] place_v;
  logic [1:0] place_user;
  logic       place_reject;
  logic       timeout;

  modport master (
    output start, abort, p0_dir, p0_place,
    output p1_dir, p1_place, occupied,
    input  curh, curv, user, place_we,
    input  place_h, place_v, place_user,
    input  place_reject, timeout
  );

  modport slave (
    input  start, abort, p0_dir, p0_place,
    input  p1_dir, p1_place, occupied,
    output curh, curv, user, place_we,
    output place_h, place_v, place_user,
    output place_reject, timeout
  );
endinterface

// File: rtl/turn_arbiter.sv
// turn_arbiter: two-player turn controller for the shared board cursor.
// Ports: clk, rst (async high); bus.slave = player inputs, occupied, cursor, writes.
module turn_arbiter #(
  parameter logic [3:0]  HMAX         = 4'd9,
  parameter logic [3:0]  VMAX         = 4'd5,
  parameter logic [24:0] COOLDOWN     = 25'h1FFFFFF,
  parameter logic [31:0] TURN_TIMEOUT = 32'd500000000
) (
  input logic           clk,
  input logic           rst,
  turn_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    TURN,
    COMMIT,
    SWITCH
  } state_t;

  state_t      state, state_n;
  logic [3:0]  curh, curh_n;
  logic [3:0]  curv, curv_n;
  logic [1:0]  user, user_n;
  logic        we, we_n;
  logic        rej, rej_n;
  logic        tmo, tmo_n;
  logic [3:0]  ph, ph_n;
  logic [3:0]  pv, pv_n;
  logic [1:0]  pu, pu_n;
  logic [24:0] cd, cd_n;
  logic [31:0] tc, tc_n;
  logic [3:0]  dir;
  logic        plc;
  logic        ready;
  logic        last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      curh  <= '0;
      curv  <= '0;
      user  <= 2'b00;
      we    <= 1'b0;
      rej   <= 1'b0;
      tmo   <= 1'b0;
      ph    <= '0;
      pv    <= '0;
      pu    <= '0;
      cd    <= '0;
      tc    <= '0;
    end else begin
      state <= state_n;
      curh  <= curh_n;
      curv  <= curv_n;
      user  <= user_n;
      we    <= we_n;
      rej   <= rej_n;
      tmo   <= tmo_n;
      ph    <= ph_n;
      pv    <= pv_n;
      pu    <= pu_n;
      cd    <= cd_n;
      tc    <= tc_n;
    end
  end

  always_comb begin
    state_n = state;
    curh_n  = curh;
    curv_n  = curv;
    user_n  = user;
    we_n    = 1'b0;
    rej_n   = 1'b0;
    tmo_n   = 1'b0;
    ph_n    = ph;
    pv_n    = pv;
    pu_n    = pu;
    cd_n    = cd;
    tc_n    = tc;
    // Only the player holding the turn is listened to.
    dir     = user[1] ? bus.p1_dir : bus.p0_dir;
    plc     = user[1] ? bus.p1_place : bus.p0_place;
    ready   = (cd == COOLDOWN);
    last    = (tc == TURN_TIMEOUT - 32'd1);
    if (bus.abort) begin
      state_n = IDLE;
      user_n  = 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          user_n = 2'b00;
          if (bus.start) begin
            state_n = TURN;
            user_n  = 2'b01;
            curh_n  = '0;
            curv_n  = '0;
            cd_n    = '0;
            tc_n    = '0;
          end
        end
        TURN: begin
          cd_n = ready ? cd : cd + 25'd1;
          tc_n = tc + 32'd1;
          if (plc && !bus.occupied) begin
            // Legal place beats a timeout in the same cycle.
            state_n = COMMIT;
            we_n    = 1'b1;
            ph_n    = curh;
            pv_n    = curv;
            pu_n    = user;
          end else begin
            if (plc) begin
              rej_n = 1'b1;
            end else if (ready) begin
              if (dir[1]) begin
                if (curh != 4'd0) curh_n = curh - 4'd1;
              end else if (dir[0]) begin
                if (curh != HMAX) curh_n = curh + 4'd1;
              end
              if (dir[2]) begin
                if (curv != VMAX) curv_n = curv + 4'd1;
              end else if (dir[3]) begin
                if (curv != 4'd0) curv_n = curv - 4'd1;
              end
              // Clamped requests keep the cooldown armed.
              if (curh_n != curh || curv_n != curv) cd_n = '0;
            end
            if (last) begin
              tmo_n   = 1'b1;
              state_n = SWITCH;
            end
          end
        end
        COMMIT: state_n = SWITCH;
        SWITCH: begin
          state_n = TURN;
          user_n  = (user == 2'b01) ? 2'b10 : 2'b01;
          cd_n    = '0;
          tc_n    = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.curh         = curh;
  assign bus.curv         = curv;
  assign bus.user         = user;
  assign bus.place_we     = we;
  assign bus.place_h      = ph;
  assign bus.place_v      = pv;
  assign bus.place_user   = pu;
  assign bus.place_reject = rej;
  assign bus.timeout      = tmo;
endmodule
